mux_select_arbiter: RTL and testbench

//   Round-robin arbiter sharing one 4:1 datapath mux (2-bit select) among four requesters.

---
 rtl/mux_select_arbiter.sv | 109 ++++++++++
 tb/tb_mux_select_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
//   Round-robin owner arbitration for one shared 4:1 datapath mux.
//   Registers a one-hot grant and the matching 2-bit mux select.
//   An owner keeps the mux until it drops req. The next owner takes over with no idle cycle.
//   Optional hold limit: define ARB_TIMEOUT_EN to revoke an owner after MAX_HOLD cycles
//   when another requester is waiting.
module mux_select_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);
  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     st;
  logic [1:0] last;      // last owner; lowest priority in the next scan
  logic       hold_lim;  // owner reached the hold limit with req still high
  logic       arb;       // arbitrate this cycle
  logic [3:0] cand;      // requests eligible in this cycle's scan
  logic       found;
  logic [1:0] win;

  // The hold counter must be able to reach MAX_HOLD.
  generate
    if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 1) begin : g_bad_cfg
      $error("mux_select_arbiter: CNT_W too narrow for MAX_HOLD");
    end
  endgenerate

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  // The owner has been visible for cnt+1 cycles, so the limit triggers at cnt == MAX_HOLD-1.
  assign hold_lim = (st == OWNED) && req[last] && (cnt >= CNT_W'(MAX_HOLD - 1));
`else
  assign hold_lim = 1'b0;
`endif

  // Re-arbitrate when idle, when the owner releases, or when the owner hits the hold limit.
  assign arb  = (st == IDLE) || !req[last] || hold_lim;
  // On a hold-limit revoke, the current owner is excluded from the scan.
  assign cand = hold_lim ? (req & ~grant) : req;
  assign busy = (st == OWNED);

  // Round-robin scan: last+1, last+2, last+3, last (mod 4). The first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && cand[last + 2'(k)]) begin
        found = 1'b1;
        win   = last + 2'(k);
      end
    end
  end

  // Owner FSM with registered grant/select. sel keeps the last owner while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      grant <= '0;
      sel   <= '0;
      last  <= 2'd3;
    end else if (arb) begin
      if (found) begin
        st    <= OWNED;
        grant <= 4'b0001 << win;
        sel   <= win;
        last  <= win;
      end else if (!hold_lim) begin
        st    <= IDLE;
        grant <= '0;
      end
      // found==0 with hold_lim: nobody else waits, so the owner keeps the grant
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter clears on every new or renewed grant. The timeout pulse accompanies a revoke.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= hold_lim && found;
      if (arb && found)
        cnt <= '0;
      else if (hold_lim)
        cnt <= '0;
      else if (!arb)
        cnt <= cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Testbench for mux_select_arbiter.
// Directed scenarios push expected outputs to a scoreboard queue when stimulus is driven.
// The expected entry is popped after the next clock edge and compared.
// A random phase then checks the structural invariants every cycle.
module tb_mux_select_arbiter;
  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_select_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grant  (grant),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] s, input logic to);
    exp_t e;
    e.g = g; e.s = s; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: grant=%b sel=%0d busy=%b timeout=%b, expected 0000/0/0/0",
               grant, sel, busy, timeout);
    end
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  // Requester 0 wins first after reset, then hands over back-to-back to 1.
  task automatic test_back_to_back();
    logic [3:0] rv [5];
    logic [3:0] gv [5];
    logic [1:0] sv [5];
    exp_t e;
    rv = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b0000};
    gv = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    sv = '{2'd0,    2'd0,    2'd1,    2'd1,    2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = rv[i];
      push(gv[i], sv[i], 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || sel !== e.s || busy !== (|e.g) || timeout !== e.to) begin
        errors++;
        $display("FAIL back_to_back[%0d]: grant=%b sel=%0d busy=%b to=%b, expected grant=%b sel=%0d busy=%b to=%b",
                 i, grant, sel, busy, timeout, e.g, e.s, |e.g, e.to);
      end
    end
  endtask

  // All four requesters request continuously. Each owner releases after 2 cycles.
  task automatic test_fairness();
    logic [3:0] rv [10];
    logic [3:0] gv [10];
    logic [1:0] sv [10];
    exp_t e;
    rv = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
           4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
    gv = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
           4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
    sv = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = rv[i];
      push(gv[i], sv[i], 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || sel !== e.s || busy !== (|e.g) || timeout !== e.to) begin
        errors++;
        $display("FAIL fairness[%0d]: grant=%b sel=%0d busy=%b to=%b, expected grant=%b sel=%0d busy=%b to=%b",
                 i, grant, sel, busy, timeout, e.g, e.s, |e.g, e.to);
      end
    end
  endtask

  // A lone req[2] pulse lasting 3 cycles. sel must stay at 2 after the grant drops.
  task automatic test_single_pulse();
    logic [3:0] rv [6];
    logic [3:0] gv [6];
    exp_t e;
    rv = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    gv = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req = rv[i];
      push(gv[i], 2'd2, 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || sel !== e.s || busy !== (|e.g) || timeout !== e.to) begin
        errors++;
        $display("FAIL single_pulse[%0d]: grant=%b sel=%0d busy=%b to=%b, expected grant=%b sel=%0d busy=%b to=%b",
                 i, grant, sel, busy, timeout, e.g, e.s, |e.g, e.to);
      end
    end
  endtask

  // Reset while requester 1 owns. Afterwards the pointer is back at 3, so 1 wins over 3 again.
  task automatic test_reset_mid_grant();
    logic       rsv [5];
    logic [3:0] rv [5];
    logic [3:0] gv [5];
    logic [1:0] sv [5];
    exp_t e;
    rsv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rv  = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
    gv  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
    sv  = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rst = rsv[i];
      req = rv[i];
      push(gv[i], sv[i], 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || sel !== e.s || busy !== (|e.g) || timeout !== e.to) begin
        errors++;
        $display("FAIL reset_mid_grant[%0d]: grant=%b sel=%0d busy=%b to=%b, expected grant=%b sel=%0d busy=%b to=%b",
                 i, grant, sel, busy, timeout, e.g, e.s, |e.g, e.to);
      end
    end
    rst = 1'b0;
  endtask

  // Hold limit (MAX_HOLD=4) when enabled; otherwise the owner holds indefinitely.
  task automatic test_hold_limit();
    logic [3:0] rv [$];
    logic [3:0] gv [$];
    logic [1:0] sv [$];
    logic       tv [$];
    exp_t e;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin rv.push_back(4'b0011); gv.push_back(4'b0001); sv.push_back(2'd0); tv.push_back(1'b0); end
    rv.push_back(4'b0011); gv.push_back(4'b0010); sv.push_back(2'd1); tv.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin rv.push_back(4'b0011); gv.push_back(4'b0010); sv.push_back(2'd1); tv.push_back(1'b0); end
    rv.push_back(4'b0011); gv.push_back(4'b0001); sv.push_back(2'd0); tv.push_back(1'b1);
    for (int i = 0; i < 8; i++) begin rv.push_back(4'b0001); gv.push_back(4'b0001); sv.push_back(2'd0); tv.push_back(1'b0); end
`else
    for (int i = 0; i < 20; i++) begin rv.push_back(4'b0011); gv.push_back(4'b0001); sv.push_back(2'd0); tv.push_back(1'b0); end
`endif
    rv.push_back(4'b0000); gv.push_back(4'b0000); sv.push_back(sv[sv.size()-1]); tv.push_back(1'b0);
    do_reset();
    for (int i = 0; i < rv.size(); i++) begin
      req = rv[i];
      push(gv[i], sv[i], tv[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || sel !== e.s || busy !== (|e.g) || timeout !== e.to) begin
        errors++;
        $display("FAIL hold_limit[%0d]: grant=%b sel=%0d busy=%b to=%b, expected grant=%b sel=%0d busy=%b to=%b",
                 i, grant, sel, busy, timeout, e.g, e.s, |e.g, e.to);
      end
    end
  endtask

  // Random level requests. Invariants are checked every cycle.
  task automatic test_random();
    logic [3:0] r  = '0;
    logic [3:0] pr;
    logic [3:0] pg = '0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      req = r;
      pr  = r;
      tick();
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL rand_onehot[%0d]: grant=%b, expected at most one bit", i, grant);
      end
      checks++;
      if (busy !== (|grant)) begin
        errors++;
        $display("FAIL rand_busy[%0d]: busy=%b, expected %b", i, busy, |grant);
      end
      checks++;
      if (grant != 4'b0000 && (grant & pr) == 4'b0000) begin
        errors++;
        $display("FAIL rand_grant_req[%0d]: grant=%b, req at arbitration=%b", i, grant, pr);
      end
      checks++;
      if ((grant != 4'b0000) !== (pr != 4'b0000)) begin
        errors++;
        $display("FAIL rand_no_bubble[%0d]: grant=%b, req at arbitration=%b", i, grant, pr);
      end
`ifdef ARB_TIMEOUT_EN
      checks++;
      if (timeout && (pg == 4'b0000 || grant == pg || grant == 4'b0000)) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: timeout=1 with grant %b -> %b", i, pg, grant);
      end
`else
      checks++;
      if (pg != 4'b0000 && (pg & pr) != 4'b0000 && grant !== pg) begin
        errors++;
        $display("FAIL rand_hold[%0d]: grant=%b, expected held %b", i, grant, pg);
      end
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL rand_timeout_tie[%0d]: timeout=%b, expected 0", i, timeout);
      end
`endif
      pg = grant;
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_fairness();
    test_single_pulse();
    test_reset_mid_grant();
    test_hold_limit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
